// File: rtl/baseband_psf_mod.sv
// Baseband BPSK/QPSK modulator with polyphase pulse-shaping FIR.
// Bits in via valid/ready; saturated I/Q samples out; host coeff RAM.
module baseband_psf_mod #(
  parameter int COEFF_W = 8,
  parameter int OUT_W   = 10,
  parameter int NTAPS   = 32,
  parameter int SPS     = 4,
  parameter int ADDR_W  = 10
) (
  input  logic                      dsp_clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  input  logic                      mode,
  input  logic                      coeff_en,
  input  logic                      rw,
  input  logic [ADDR_W-1:0]         coeff_addr,
  input  logic [COEFF_W-1:0]        coeff_in,
  output logic [COEFF_W-1:0]        coeff_rd_data,
  output logic                      coeff_rd_valid,
  output logic                      coeff_err,
  output logic signed [OUT_W-1:0]   i_out,
  output logic signed [OUT_W-1:0]   q_out,
  output logic                      out_valid
);

  localparam int L     = NTAPS / SPS;
  localparam int LW    = (L > 1) ? $clog2(L) : 1;
  localparam int KW    = $clog2(L + 1);
  localparam int PW    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int IW    = $clog2(NTAPS);
  localparam int ACC_W = COEFF_W + $clog2(L) + 1;

  localparam logic [KW-1:0]     K_OUT  = KW'(L);
  localparam logic [KW-1:0]     K_LAST = KW'(L - 1);
  localparam logic [PW-1:0]     P_LAST = PW'(SPS - 1);
  localparam logic [ADDR_W-1:0] NT_A   = ADDR_W'(NTAPS);
  localparam logic signed [ACC_W-1:0] OMAX =
    ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OMIN =
    ACC_W'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, GATHER, SHAPE} state_t;

  state_t state, state_nx;

  // symbols as 2-bit signed: 01 = +1, 11 = -1, 00 = 0
  logic [L-1:0][1:0]             sym_i, sym_q;
  logic [L-1:0][1:0]             shf_i, shf_q;
  logic [NTAPS-1:0][COEFF_W-1:0] ram;

  logic                      mode_q, g, last_g, enter_g, line_zero;
  logic [1:0]                cur, held_i, new_i, new_q;
  logic [KW-1:0]             k;
  logic [PW-1:0]             p;
  logic [LW-1:0]             kk;
  logic [IW-1:0]             tap_idx;
  logic signed [ACC_W-1:0]   acc_i, acc_q, acc_i_nx, acc_q_nx;

  function automatic logic signed [ACC_W-1:0] term(
    input logic [1:0] s,
    input logic [COEFF_W-1:0] c
  );
    logic signed [ACC_W-1:0] ce;
    ce = {{(ACC_W-COEFF_W){c[COEFF_W-1]}}, c};
    case (s)
      2'b01:   return ce;
      2'b11:   return -ce;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(
    input logic signed [ACC_W-1:0] a
  );
    if (a > OMAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (a < OMIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else               return a[OUT_W-1:0];
  endfunction

  assign bit_ready = (state == GATHER);
  assign last_g    = (g == mode_q);
  assign kk        = k[LW-1:0];
  assign tap_idx   = IW'(int'(kk) * SPS + int'(p));

  // new symbol assembly, shifted delay line and accumulator update
  always_comb begin
    cur = 2'b00;
    if (bit_valid) cur = bit_in ? 2'b11 : 2'b01;
    new_i = cur;
    new_q = 2'b00;
    if (mode_q) begin
      new_i = held_i;
      new_q = cur;
    end
    shf_i     = {sym_i[L-2:0], new_i};
    shf_q     = {sym_q[L-2:0], new_q};
    line_zero = (shf_i == '0) && (shf_q == '0);
    acc_i_nx  = acc_i + term(sym_i[kk], ram[tap_idx]);
    acc_q_nx  = acc_q + term(sym_q[kk], ram[tap_idx]);
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    enter_g  = 1'b0;
    case (state)
      IDLE: if (bit_valid) begin
        state_nx = GATHER;
        enter_g  = 1'b1;
      end
      GATHER: if (last_g) state_nx = line_zero ? IDLE : SHAPE;
      SHAPE: if (k == K_OUT && p == P_LAST) begin
        state_nx = GATHER;
        enter_g  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM, gather, delay line, shaping datapath and outputs
  always_ff @(posedge dsp_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      g         <= 1'b0;
      held_i    <= 2'b00;
      sym_i     <= '0;
      sym_q     <= '0;
      k         <= '0;
      p         <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      i_out     <= '0;
      q_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (enter_g) mode_q <= mode;
      if (state == GATHER) begin
        g <= last_g ? 1'b0 : 1'b1;
        if (!g) held_i <= cur;
        if (last_g) begin
          sym_i <= shf_i;
          sym_q <= shf_q;
        end
      end
      if (state == SHAPE) begin
        if (k == K_OUT) begin
          k     <= '0;
          p     <= (p == P_LAST) ? '0 : p + 1'b1;
          acc_i <= '0;
          acc_q <= '0;
        end else begin
          k     <= k + 1'b1;
          acc_i <= acc_i_nx;
          acc_q <= acc_q_nx;
          if (k == K_LAST) begin
            i_out     <= sat(acc_i_nx);
            q_out     <= sat(acc_q_nx);
            out_valid <= 1'b1;
          end
        end
      end else begin
        k     <= '0;
        p     <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end
    end
  end

  // coefficient RAM host port, only honoured while idle
  always_ff @(posedge dsp_clk or posedge rst) begin
    if (rst) begin
      ram            <= '0;
      coeff_rd_data  <= '0;
      coeff_rd_valid <= 1'b0;
      coeff_err      <= 1'b0;
    end else begin
      coeff_rd_valid <= 1'b0;
      coeff_err      <= 1'b0;
      if (coeff_en) begin
        if (state != IDLE) begin
          coeff_err <= 1'b1;
        end else if (rw) begin
          if (coeff_addr < NT_A) ram[coeff_addr[IW-1:0]] <= coeff_in;
        end else begin
          coeff_rd_valid <= 1'b1;
          coeff_rd_data  <= (coeff_addr < NT_A) ?
                            ram[coeff_addr[IW-1:0]] : '0;
        end
      end
    end
  end

endmodule
